// File: rtl/saradc_pkg.sv
// Shared definitions for the SAR ADC controller: FSM states, default sizing
// and the comparator synchronizer depth.
package saradc_pkg;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SAMPLE_CYCLES = 8;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int CMP_SYNC_STAGES   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_SETTLE,
        ST_DECIDE,
        ST_DONE
    } sar_state_t;

    // Counter width able to hold max(a, b).
    function automatic int cnt_bits(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/saradc_sync2.sv
// Multi-flop synchronizer bringing the asynchronous comparator output into
// the clk domain; clears to 0 on reset.
module saradc_sync2
    import saradc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [CMP_SYNC_STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[CMP_SYNC_STAGES-2:0], d};
        end
    end

    assign q = sr[CMP_SYNC_STAGES-1];

endmodule

// File: rtl/saradc_sar_ctrl.sv
// Successive-approximation controller: samples, walks the DAC code MSB to LSB
// against the comparator, and buffers one result behind a valid/ready port.
module saradc_sar_ctrl
    import saradc_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample_en,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int CW = cnt_bits(SAMPLE_CYCLES, SETTLE_CYCLES);
    localparam int BW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};

    sar_state_t       state;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bit_idx;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] decide_code;
    logic             cmp_sync;

    saradc_sync2 u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_in),
        .q     (cmp_sync)
    );

    // Keep or drop the bit under test, then arm the next lower bit.
    always_comb begin
        decide_code = trial;
        if (!cmp_sync) begin
            decide_code[bit_idx] = 1'b0;
        end
        if (bit_idx != '0) begin
            decide_code[bit_idx - BW'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            trial        <= '0;
            sample_en    <= 1'b0;
            dac_code     <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            // A DONE load later in this block overrides the consume.
            if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    dac_code  <= '0;
                    sample_en <= 1'b0;
                    if (start) begin
                        state <= ST_SAMPLE;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end

                // sample_en is registered, so the track window trails state
                // entry by one cycle and spans exactly SAMPLE_CYCLES cycles.
                ST_SAMPLE: begin
                    if (cnt == CW'(SAMPLE_CYCLES)) begin
                        sample_en <= 1'b0;
                        cnt       <= '0;
                        bit_idx   <= BW'(WIDTH - 1);
                        trial     <= MSB_CODE;
                        dac_code  <= MSB_CODE;
                        state     <= ST_SETTLE;
                    end else begin
                        sample_en <= 1'b1;
                        cnt       <= cnt + CW'(1);
                    end
                end

                ST_SETTLE: begin
                    if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= ST_DECIDE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_DECIDE: begin
                    trial    <= decide_code;
                    dac_code <= decide_code;
                    if (bit_idx != '0) begin
                        bit_idx <= bit_idx - BW'(1);
                        state   <= ST_SETTLE;
                    end else begin
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (!result_valid || result_ready) begin
                        result       <= trial;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// Bench for saradc_sar_ctrl: an ideal comparator model drives cmp_in and the
// expected trial sequence, result and latency come from plain SAR arithmetic.
module tb_saradc_sar_ctrl;

    localparam int W   = 8;
    localparam int S   = 8;
    localparam int T   = 4;
    localparam int LAT = S + W * (T + 1) + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         result_ready = 1'b0;
    logic         cmp_in;
    logic         sample_en;
    logic         busy;
    logic         result_valid;
    logic [W-1:0] dac_code;
    logic [W-1:0] result;

    logic [W-1:0] vin = '0;
    logic         use_rand = 1'b1;
    logic         cmp_rand = 1'b0;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    assign cmp_in = use_rand ? cmp_rand : (vin >= dac_code);

    always #5 clk = ~clk;

    saradc_sar_ctrl #(
        .WIDTH         (W),
        .SAMPLE_CYCLES (S),
        .SETTLE_CYCLES (T)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cmp_in       (cmp_in),
        .sample_en    (sample_en),
        .dac_code     (dac_code),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Binary search: bit b is tried on top of the already-resolved upper bits.
    task automatic model_seq(input logic [W-1:0] v);
        int t;
        exp_q.delete();
        for (int b = W - 1; b >= 0; b--) begin
            t = ((int'(v) >> (b + 1)) << (b + 1)) | (1 << b);
            exp_q.push_back(W'(t));
        end
        if (v != exp_q[$] && v != '0) exp_q.push_back(v);
    endtask

    task automatic conv(input logic [W-1:0] v, input bit consume, input string tag);
        int lat, sen, bad_s, n;
        vin = v;
        model_seq(v);
        got_q.delete();
        lat = -1; sen = 0; bad_s = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= LAT + 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (sample_en) begin
                sen++;
                if (dac_code != '0) bad_s++;
            end else if (busy && dac_code != '0 &&
                         (got_q.size() == 0 || got_q[$] != dac_code)) begin
                got_q.push_back(dac_code);
            end
            if (result_valid) begin
                lat = k - 1;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(LAT));
        chk({tag, "_sample_cycles"}, 32'(sen), 32'(S));
        chk({tag, "_sample_dac_zero"}, 32'(bad_s), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'(v));
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_trial_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_trial%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        if (consume) begin
            @(negedge clk);
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
            chk({tag, "_consumed"}, 32'(result_valid), 32'd0);
        end
    endtask

    initial begin
        int nz, nres, found;
        logic [W-1:0] seen;
        logic prev_v;

        // Reset with random activity on every input.
        #2 rst_n = 1'b0;
        repeat (6) begin
            @(negedge clk);
            start        = 1'($urandom_range(0, 1));
            result_ready = 1'($urandom_range(0, 1));
            cmp_rand     = 1'($urandom_range(0, 1));
            vin          = W'($urandom);
            #1;
            chk("reset_outputs", 32'({busy, sample_en, result_valid, dac_code, result}), 32'd0);
        end
        start = 1'b0;
        result_ready = 1'b0;
        use_rand = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        nz = 0;
        repeat (100) begin
            @(negedge clk);
            if ({busy, sample_en, result_valid, dac_code, result} != '0) nz++;
        end
        chk("idle_no_start", 32'(nz), 32'd0);

        conv(8'hA5, 1'b1, "a5");
        conv(8'hFF, 1'b1, "ff");
        conv(8'h00, 1'b1, "zero");
        for (int r = 0; r < 6; r++) begin
            conv(W'($urandom_range(0, 255)), 1'b1, $sformatf("rnd%0d", r));
        end

        // Backpressure: second result must stall in DONE until ready.
        result_ready = 1'b0;
        conv(8'h3C, 1'b0, "bp_first");
        vin = 8'hC3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (LAT + 20) @(negedge clk);
        chk("bp_busy_held", 32'(busy), 32'd1);
        chk("bp_valid_held", 32'(result_valid), 32'd1);
        chk("bp_result_held", 32'(result), 32'h3C);
        chk("bp_dac_final", 32'(dac_code), 32'hC3);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_load_valid", 32'(result_valid), 32'd1);
        chk("bp_load_result", 32'(result), 32'hC3);
        chk("bp_load_busy", 32'(busy), 32'd0);
        @(negedge clk);
        result_ready = 1'b0;
        @(negedge clk);
        chk("bp_second_kept", 32'(result), 32'hC3);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("bp_drained", 32'(result_valid), 32'd0);

        // Start pulses while busy must not spawn extra conversions.
        vin = 8'h96;
        nres = 0; seen = '0; prev_v = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = (k == 10 || k == 25 || k == 40);
            if (result_valid && !prev_v) begin
                nres++;
                seen = result;
            end
            prev_v = result_valid;
            result_ready = result_valid;
        end
        start = 1'b0;
        result_ready = 1'b0;
        chk("busy_start_count", 32'(nres), 32'd1);
        chk("busy_start_result", 32'(seen), 32'h96);

        // Reset while bit 4 settles, with an older result still pending.
        conv(8'h3A, 1'b0, "pend");
        vin = 8'h77;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dac_code == 8'h70) begin
                found = 1;
                break;
            end
        end
        chk("rm_reached_bit4", 32'(found), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_outputs_zero", 32'({busy, sample_en, result_valid, dac_code, result}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        conv(8'h5A, 1'b1, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
